// File: rtl/znmi_arb.sv
// znmi_arb: prioritised multi-source NMI arbiter for a Z80 system.
// Handles request capture, ROM-fetch guarding, the NMI pulse, and the refresh-timed exit.
`default_nettype none

module znmi_arb #(
  parameter int NSRC      = 4,
  parameter int PULSE_LEN = 16,
  parameter int CLR_RFSH  = 3,
  parameter int SYNC_INT  = 1
) (
  input  logic            fclk,
  input  logic            rst_n,
  input  logic            zpos,
  input  logic            zneg,
  input  logic            int_start,
  input  logic [NSRC-1:0] set_nmi,
  input  logic [NSRC-1:0] src_mask,
  input  logic            clr_nmi,
  input  logic            rfsh_n,
  input  logic            m1_n,
  input  logic            mreq_n,
  input  logic            csrom,
  input  logic [15:0]     a,
  output logic            in_nmi,
  output logic            gen_nmi,
  output logic [NSRC-1:0] nmi_cause,
  output logic [NSRC-1:0] pending
);

  localparam int PW = $clog2(PULSE_LEN + 1);

  logic [NSRC-1:0] set_q, pend_q, pend_d, cause_q, cause_d;
  logic [NSRC-1:0] w_edge, w_win;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [3:0]      ccnt_q, ccnt_d;
  logic            arm_q, arm_d, in_nmi_q, in_nmi_d;
  logic            m1_smp_q, mreq_smp_q, was_m1_prev_q;
  logic            rom_q, rom_d;
  logic            w_was_m1, w_trig, w_grant;
  logic            unused_addr;

  assign unused_addr = ^a[13:0];

  assign w_edge   = set_q & ~set_nmi;
  assign w_win    = pend_q & (~pend_q + 1'b1);
  assign w_was_m1 = ~m1_smp_q & ~mreq_smp_q;
  assign w_trig   = (SYNC_INT != 0) ? int_start : zpos;
  assign gen_nmi  = (pcnt_q != '0);
  assign w_grant  = w_trig & (|pend_q) & ~in_nmi_q & ~gen_nmi & ~rom_q;

  always_comb begin
    pend_d   = (pend_q & ~(w_grant ? w_win : '0)) | (w_edge & src_mask);
    cause_d  = cause_q;
    in_nmi_d = in_nmi_q;
    arm_d    = arm_q;
    ccnt_d   = ccnt_q;
    pcnt_d   = pcnt_q;
    rom_d    = rom_q;

    if (w_was_m1 && !was_m1_prev_q)
      rom_d = csrom & (a[15:14] == 2'b00);

    if (w_grant) begin
      in_nmi_d = 1'b1;
      cause_d  = w_win;
      pcnt_d   = PW'(PULSE_LEN);
    end else if (pcnt_q != '0) begin
      pcnt_d = pcnt_q - 1'b1;
    end

    // A fresh clr_nmi always restarts the countdown, even when it is about to expire.
    if (clr_nmi && in_nmi_q) begin
      arm_d  = 1'b1;
      ccnt_d = 4'(CLR_RFSH);
    end else if (arm_q) begin
      if (ccnt_q == 4'd0) begin
        arm_d    = 1'b0;
        in_nmi_d = 1'b0;
        cause_d  = '0;
      end else if (zpos && !rfsh_n) begin
        ccnt_d = ccnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      set_q         <= '1;
      pend_q        <= '0;
      cause_q       <= '0;
      in_nmi_q      <= 1'b0;
      arm_q         <= 1'b0;
      ccnt_q        <= 4'd0;
      pcnt_q        <= '0;
      rom_q         <= 1'b0;
      m1_smp_q      <= 1'b1;
      mreq_smp_q    <= 1'b1;
      was_m1_prev_q <= 1'b0;
    end else begin
      set_q         <= set_nmi;
      pend_q        <= pend_d;
      cause_q       <= cause_d;
      in_nmi_q      <= in_nmi_d;
      arm_q         <= arm_d;
      ccnt_q        <= ccnt_d;
      pcnt_q        <= pcnt_d;
      rom_q         <= rom_d;
      was_m1_prev_q <= w_was_m1;
      if (zpos) m1_smp_q   <= m1_n;
      if (zneg) mreq_smp_q <= mreq_n;
    end
  end

  assign in_nmi    = in_nmi_q;
  assign nmi_cause = cause_q;
  assign pending   = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_znmi_arb.sv
// tb_znmi_arb: directed self-checking bench for znmi_arb with default parameters.
`default_nettype none
`timescale 1ns/1ps

module tb_znmi_arb;

  logic        fclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        zpos = 1'b0, zneg = 1'b0, int_start = 1'b0, clr_nmi = 1'b0;
  logic        rfsh_n = 1'b1, m1_n = 1'b1, mreq_n = 1'b1, csrom = 1'b0;
  logic [3:0]  set_nmi = 4'hF, src_mask = 4'hF;
  logic [15:0] a = 16'h0000;
  logic        in_nmi, gen_nmi;
  logic [3:0]  nmi_cause, pending;

  int n_tests = 0;
  int n_fail  = 0;

  znmi_arb dut (
    .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .zneg(zneg), .int_start(int_start),
    .set_nmi(set_nmi), .src_mask(src_mask), .clr_nmi(clr_nmi), .rfsh_n(rfsh_n),
    .m1_n(m1_n), .mreq_n(mreq_n), .csrom(csrom), .a(a),
    .in_nmi(in_nmi), .gen_nmi(gen_nmi), .nmi_cause(nmi_cause), .pending(pending)
  );

  always #5 fclk = ~fclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge fclk);
      #1;
    end
  endtask

  task automatic edge_src(input int i);
    set_nmi[i] = 1'b0; tick();
    set_nmi[i] = 1'b1; tick();
  endtask

  task automatic do_int();
    int_start = 1'b1; tick();
    int_start = 1'b0;
  endtask

  task automatic do_clr();
    clr_nmi = 1'b1; tick();
    clr_nmi = 1'b0;
  endtask

  task automatic refresh(input int n);
    repeat (n) begin
      zpos = 1'b1; rfsh_n = 1'b0; tick();
      zpos = 1'b0; rfsh_n = 1'b1; tick();
    end
  endtask

  // Counts gen_nmi-high cycles from now; bounded so a stuck pulse cannot hang the run.
  task automatic pulse_len(output int len);
    len = 0;
    while (gen_nmi && len < 100) begin
      len++;
      tick();
    end
  endtask

  task automatic fetch(input logic rom, input logic [15:0] addr);
    csrom = rom; a = addr; m1_n = 1'b0; mreq_n = 1'b0;
    zpos = 1'b1; tick(); zpos = 1'b0;
    zneg = 1'b1; tick(); zneg = 1'b0;
    tick();
    m1_n = 1'b1; mreq_n = 1'b1;
    zpos = 1'b1; tick(); zpos = 1'b0;
    zneg = 1'b1; tick(); zneg = 1'b0;
    tick();
    csrom = 1'b0; a = 16'h0000;
  endtask

  initial begin
    int len;
    tick(2);
    chk("rst_in_nmi", in_nmi, 0);
    chk("rst_gen", gen_nmi, 0);
    chk("rst_cause", nmi_cause, 0);
    chk("rst_pending", pending, 0);
    rst_n = 1'b1;
    tick();

    // Single request on source 2
    edge_src(2);
    chk("s2_pending", pending, 4'b0100);
    do_int();
    chk("s2_in_nmi", in_nmi, 1);
    chk("s2_cause", nmi_cause, 4'b0100);
    chk("s2_pend_clr", pending, 0);
    pulse_len(len);
    chk("s2_pulse_len", len, 16);
    do_clr(); refresh(3);
    chk("s2_exit", in_nmi, 0);
    chk("s2_exit_cause", nmi_cause, 0);

    // Priority: sources 3 and 1 together
    edge_src(3); edge_src(1);
    chk("pri_pending", pending, 4'b1010);
    do_int();
    chk("pri_cause1", nmi_cause, 4'b0010);
    chk("pri_pend_left", pending, 4'b1000);
    pulse_len(len);
    do_int();
    chk("pri_no_regrant", nmi_cause, 4'b0010);
    do_clr(); refresh(3);
    chk("pri_exit1", in_nmi, 0);
    do_int();
    chk("pri_cause3", nmi_cause, 4'b1000);
    chk("pri_pend_empty", pending, 0);
    pulse_len(len);
    do_clr(); refresh(3);
    chk("pri_exit3", in_nmi, 0);

    // Masked source discarded
    src_mask = 4'b1110;
    edge_src(0);
    chk("mask_pending", pending, 0);
    do_int();
    chk("mask_gen", gen_nmi, 0);
    chk("mask_in_nmi", in_nmi, 0);
    src_mask = 4'hF;

    // Clear ignored while idle
    do_clr(); refresh(1);
    chk("idle_clr", in_nmi, 0);

    // ROM fetch blocks the grant, RAM fetch re-enables it
    fetch(1'b1, 16'h0100);
    edge_src(1);
    do_int();
    chk("rom_no_grant", in_nmi, 0);
    chk("rom_no_gen", gen_nmi, 0);
    chk("rom_pend_kept", pending, 4'b0010);
    fetch(1'b0, 16'h8000);
    do_int();
    chk("ram_grant", in_nmi, 1);
    chk("ram_cause", nmi_cause, 4'b0010);
    pulse_len(len);
    do_clr(); refresh(3);

    // Re-armed clear restarts the refresh count
    edge_src(0);
    do_int();
    chk("rearm_cause", nmi_cause, 4'b0001);
    pulse_len(len);
    do_clr(); refresh(2);
    chk("rearm_hold1", in_nmi, 1);
    do_clr(); refresh(2);
    chk("rearm_hold2", in_nmi, 1);
    refresh(1);
    chk("rearm_exit", in_nmi, 0);

    // Reset mid-pulse
    edge_src(3);
    do_int();
    edge_src(1);
    tick(2);
    chk("mid_gen", gen_nmi, 1);
    chk("mid_pend", pending, 4'b0010);
    rst_n = 1'b0; #1;
    chk("arst_in_nmi", in_nmi, 0);
    chk("arst_gen", gen_nmi, 0);
    chk("arst_cause", nmi_cause, 0);
    chk("arst_pending", pending, 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_int();
    chk("post_rst_gen", gen_nmi, 0);
    chk("post_rst_in_nmi", in_nmi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/znmi_arb.md
ZNMI_ARB -- requirements
Module: znmi_arb

Interface
REQ-001 The block SHALL have a parameter NSRC, default 4, giving the number of NMI request sources (range 1..8).
REQ-002 The block SHALL have a parameter PULSE_LEN, default 16, giving the gen_nmi pulse length in fclk cycles (range 1..255).
REQ-003 The block SHALL have a parameter CLR_RFSH, default 3, giving the number of refresh cycles from clr_nmi to in_nmi release (range 1..15).
REQ-004 The block SHALL have a parameter SYNC_INT, default 1: 1 = grant only on int_start; 0 = grant on any zpos strobe.
REQ-005 fclk  in  1  system clock; the only clock; all state on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 zpos, zneg  in  1 each  Z80 clock edge strobes, one fclk wide.
REQ-008 int_start  in  1  one-cycle strobe at INT start.
REQ-009 set_nmi  in  NSRC  per-source request; a request is its 1->0 transition.
REQ-010 src_mask  in  NSRC  per-source enable, 1 = enabled.
REQ-011 clr_nmi  in  1  one-cycle NMI-exit strobe from the port decoder.
REQ-012 rfsh_n, m1_n, mreq_n  in  1 each  Z80 bus controls.
REQ-013 csrom  in  1  ROM chip-select.
REQ-014 a  in  16  Z80 address bus.
REQ-015 in_nmi  out  1  NMI service active; forces last RAM page into 0000-3FFF.
REQ-016 gen_nmi  out  1  1 = drive NMI_N low.
REQ-017 nmi_cause  out  NSRC  one-hot identity of the source being served; 0 when idle.
REQ-018 pending  out  NSRC  per-source pending request flags.

Function
REQ-019 set_nmi SHALL be registered each fclk; edge[i] = prev[i] & ~set_nmi[i].
REQ-020 pending[i] SHALL set on edge[i] when src_mask[i]=1; an edge with src_mask[i]=0 SHALL be discarded.
REQ-021 pending[i] SHALL clear only on grant of source i or on reset; clearing src_mask does not clear it.
REQ-022 If edge[i] coincides with the grant of source i, pending[i] SHALL remain 1 (set wins).
REQ-023 m1_n SHALL be sampled on zpos and mreq_n on zneg; was_m1 = both sampled low.
REQ-024 On each fclk where was_m1 rises, last_m1_rom SHALL latch csrom & (a[15:14]==0).
REQ-025 trig = int_start if SYNC_INT=1, else zpos.
REQ-026 Grant SHALL occur when trig & |pending & ~in_nmi & ~gen_nmi & ~last_m1_rom.
REQ-027 When last_m1_rom=1 at trig, no grant SHALL occur and all pending bits SHALL be kept.
REQ-028 The winner SHALL be the lowest-index pending source.
REQ-029 On grant, next cycle: in_nmi=1, nmi_cause=one-hot(winner), pending[winner]=0, pulse counter=PULSE_LEN.
REQ-030 gen_nmi SHALL be (pulse counter != 0); the counter decrements each fclk to 0, so gen_nmi is high for exactly PULSE_LEN cycles starting the cycle after grant.
REQ-031 The pulse counter SHALL be ceil(log2(PULSE_LEN+1)) bits wide and SHALL never wrap below 0.
REQ-032 clr_nmi with in_nmi=1 SHALL arm the clear and load the clear counter with CLR_RFSH; clr_nmi with in_nmi=0 SHALL be ignored.
REQ-033 A further clr_nmi while armed SHALL reload CLR_RFSH.
REQ-034 While armed, the clear counter SHALL decrement on each zpos with rfsh_n=0.
REQ-035 The fclk after the clear counter reaches 0 while armed, in_nmi and nmi_cause SHALL go to 0 and the arm SHALL drop.
REQ-036 A grant SHALL be possible no earlier than the cycle after in_nmi falls; pending requests are then served in priority order.

Reset
REQ-037 With rst_n=0, the block SHALL asynchronously force in_nmi=0, gen_nmi=0, nmi_cause=0, pending=0, pulse counter=0, clear arm=0, clear counter=0, last_m1_rom=0 and registered set_nmi=all 1.
REQ-038 Reset asserted mid-pulse or mid-clear SHALL terminate the operation immediately; no request SHALL survive reset.

Verification
REQ-039 NSRC=4 defaults; set_nmi[2] 1->0, then int_start -> gen_nmi high for 16 cycles; in_nmi=1; nmi_cause=4'b0100; pending=0.
REQ-040 Edges on sources 3 and 1 before one int_start -> source 1 served first (cause 0010); after clr_nmi and 3 refresh zpos, source 3 is served at the next int_start (cause 1000).
REQ-041 src_mask=4'b1110, edge on source 0 -> pending stays 0; int_start produces no gen_nmi.
REQ-042 Opcode fetch from ROM at 0x0100 sets last_m1_rom, then a request and int_start -> no grant, pending retained; fetch from RAM at 0x8000, then int_start -> grant.
REQ-043 In_nmi=1, clr_nmi, 2 refresh zpos, second clr_nmi, 3 refresh zpos -> in_nmi falls only after the 3rd refresh following the second clr_nmi.
REQ-044 rst_n low during cycle 5 of the gen_nmi pulse -> all outputs 0 immediately; a subsequent int_start with no new edges gives no NMI.
